// File: rtl/store_narrow_pkg.sv
// store_narrow_pkg: shared types and constants for the store narrowing path (size encoding, lane geometry, formatted-store record)
package store_narrow_pkg;
  localparam int NUM_LANES = 4;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;
  typedef struct packed {
    logic [NUM_LANES*BYTE_W-1:0] wdata;
    logic [NUM_LANES-1:0]        wstrb;
    logic                        err;
    logic                        ovf;
  } st_fmt_t;
endpackage

// File: rtl/store_narrow_if.sv
// store_narrow_if: request side (in_valid/in_ready/in_data/in_addr_lo/in_size/in_signed) and store side (out_valid/out_ready/out_wdata/out_wstrb/out_err/out_ovf); slave = block, master = driver
interface store_narrow_if import store_narrow_pkg::*; #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_addr_lo;
  size_t             in_size;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_wdata;
  logic [3:0]        out_wstrb;
  logic              out_err;
  logic              out_ovf;
  modport slave (input in_valid, in_data, in_addr_lo, in_size, in_signed, out_ready,
                 output in_ready, out_valid, out_wdata, out_wstrb, out_err, out_ovf);
  modport master (output in_valid, in_data, in_addr_lo, in_size, in_signed, out_ready,
                  input in_ready, out_valid, out_wdata, out_wstrb, out_err, out_ovf);
endinterface

// File: rtl/store_fmt.sv
// store_fmt: combinational lane replication, strobe, error and overflow for one store (in: data, addr_lo, size, sgn; out: fmt)
module store_fmt import store_narrow_pkg::*; (
  input  logic [NUM_LANES*BYTE_W-1:0] data,
  input  logic [1:0]                  addr_lo,
  input  size_t                       size,
  input  logic                        sgn,
  output st_fmt_t                     fmt
);
  logic byte_ovf, half_ovf, err;
  logic [NUM_LANES-1:0] strb;
  assign byte_ovf = sgn ? !(&data[31:BYTE_W-1] || !(|data[31:BYTE_W-1])) : |data[31:BYTE_W];
  assign half_ovf = sgn ? !(&data[31:HALF_W-1] || !(|data[31:HALF_W-1])) : |data[31:HALF_W];
  assign err = (size == SZ_RSVD) || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'd0);
  assign strb = size == SZ_BYTE ? 4'b0001 << addr_lo : size == SZ_HALF ? 4'b0011 << addr_lo : 4'b1111;
  assign fmt.wdata = size == SZ_BYTE ? {4{data[BYTE_W-1:0]}} : size == SZ_HALF ? {2{data[HALF_W-1:0]}} : data;
  assign fmt.wstrb = err ? '0 : strb;
  assign fmt.err = err;
  assign fmt.ovf = !err && (size == SZ_BYTE ? byte_ovf : (size == SZ_HALF && half_ovf));
endmodule

// File: rtl/store_narrow.sv
// store_narrow: formats register stores into byte lanes behind a 2-entry skid buffer (ports: clk, reset, bus slave, cnt_clr, ovf_count)
module store_narrow import store_narrow_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  store_narrow_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);
  st_fmt_t fmt, out_q, skid_q;
  logic out_valid_q, skid_valid_q, in_fire, out_fire;
  if (DATA_W != NUM_LANES*BYTE_W) begin : g_width_chk
    $error("store_narrow supports only 32-bit data");
  end
  store_fmt u_fmt (
    .data    (bus.in_data),
    .addr_lo (bus.in_addr_lo),
    .size    (bus.in_size),
    .sgn     (bus.in_signed),
    .fmt     (fmt)
  );
  assign bus.in_ready  = !skid_valid_q && !reset;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_wdata = out_q.wdata;
  assign bus.out_wstrb = out_q.wstrb;
  assign bus.out_err   = out_q.err;
  assign bus.out_ovf   = out_q.ovf;
  // A full skid register holds in_ready low, so it never competes with a new input for the output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_fire) begin
      out_valid_q  <= skid_valid_q || in_fire;
      skid_valid_q <= 1'b0;
      if (skid_valid_q) out_q <= skid_q;
      else if (in_fire) out_q <= fmt;
    end else if (in_fire) begin
      skid_q       <= fmt;
      skid_valid_q <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_count <= '0;
    else if (cnt_clr) ovf_count <= '0;
    else if (out_fire && out_q.ovf && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
  end
endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-path partner of the load sign extender. It narrows a 32-bit register value to a byte, half or word store.
- It places the value on the correct byte lanes and generates write strobes.
- It flags misaligned or invalid sizes and reports truncation overflow, i.e. cases where sign or zero extension of the narrowed value would not reproduce the original.
- It sits between the EX/MEM register and the data-memory write port, with a valid/ready handshake and a 2-entry skid buffer.

Parameters:
- DATA_W, 32, data width. Only 32 is supported; 4 byte lanes.
- CNT_W, 16, width of the saturating overflow event counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_data  in  DATA_W  register value to store
- in_addr_lo  in  2  byte offset of the store address
- in_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- in_signed  in  1  1 = overflow is checked as signed narrowing; 0 = unsigned
- out_valid  out  1  formatted store valid
- out_ready  in  1  memory port accepts
- out_wdata  out  DATA_W  lane-replicated store data
- out_wstrb  out  4  byte write strobes; bit i = byte i
- out_err  out  1  misaligned access or reserved size
- out_ovf  out  1  truncation lost information
- ovf_count  out  CNT_W  number of accepted outputs with out_ovf=1, saturating
- cnt_clr  in  1  synchronous clear of ovf_count

Behaviour:
- Reset, asynchronous, active-high, clk-domain only:
  - out_valid=0, out_wdata=0, out_wstrb=0, out_err=0, out_ovf=0, ovf_count=0.
  - Skid register empty.
  - in_ready is forced to 0 while reset is high.
  - Any in-flight entry is discarded; no partial output appears after reset releases.
- Handshakes:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - in_ready = !skid_valid, driven from a register only; no combinational path from out_ready.
- Buffering:
  - On an input transfer: if the output register is empty or is transferring this cycle, the formatted result loads the output register. Otherwise it loads the skid register.
  - On an output transfer with the skid register full, the skid entry moves to the output register and the skid register empties.
  - Order is strictly preserved. Throughput is 1 per cycle with out_ready held high.
- Latency: 1 cycle from input transfer to out_valid.
- Outputs are stable while out_valid & !out_ready.
- Formatting is combinational on input and registered into the buffer:
  - Byte: wdata={4{data[7:0]}}, wstrb=4'b0001<<addr_lo. Never misaligned.
  - Half: wdata={2{data[15:0]}}, wstrb=4'b0011<<addr_lo. Misaligned if addr_lo[0]=1.
  - Word: wdata=data, wstrb=4'b1111. Misaligned if addr_lo!=0.
  - Reserved size 11: err=1.
  - Whenever err=1: wstrb=4'b0000 and ovf=0, with wdata still formatted as above. For size 11, wdata=data.
- Overflow, with N = 8 (byte) or 16 (half):
  - Signed: ovf=1 unless data[31:N-1] is all zeros or all ones.
  - Unsigned: ovf=1 unless data[31:N]==0.
  - Word: ovf=0.
- ovf_count:
  - Increments on each output transfer with out_ovf=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle; the result is 0.
- Erroneous requests still flow through the handshake and are not dropped.

Decomposition:
- Package store_narrow_pkg holds:
  - enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}
  - localparams NUM_LANES=4, BYTE_W=8, HALF_W=16
  - packed struct st_fmt_t {wdata, wstrb, err, ovf}
- One sub-module, store_fmt: the purely combinational format/overflow function, instantiated once ahead of the buffer.
- The skid buffer and the counter stay in store_narrow.

Test Plan:
- Byte: data=0x0000_00A5, addr_lo=2, size=byte, signed=1, out_ready=1 -> one cycle later wdata=0xA5A5_A5A5, wstrb=0100, err=0, ovf=1 (0xA5 reads as negative, upper bits are zero); ovf_count=1.
- Half: data=0xFFFF_8001, addr_lo=2, size=half, signed=1 -> wdata=0x8001_8001, wstrb=1100, ovf=0. Same value with signed=0 -> ovf=1.
- Misaligned and reserved: word store with addr_lo=1 -> wstrb=0000, err=1, ovf=0, handshake completes. size=11 -> err=1, wstrb=0000.
- Backpressure: hold out_ready=0 and drive 3 back-to-back requests.
  - Required: two are accepted; in_ready drops after the 2nd; outputs are held stable.
  - Then release out_ready=1. Required: all 3 drain in order with no loss or duplication.
- Counter: 70000 overflowing byte stores with CNT_W=16 -> ovf_count saturates at 65535. cnt_clr asserted together with an ovf transfer -> ovf_count=0.
- Reset mid-operation: assert reset with both buffer entries full -> out_valid=0 and in_ready=0 immediately. After release: in_ready=1, no stale output appears, ovf_count=0.
